if_id_buf: RTL and testbench
============================

# if_id_buf

Parametrised IF/ID pipeline boundary between fetch and decode, replacing the free-running IF/ID latch. Carries PC and instruction with a valid/ready handshake on both sides, supports decode back-pressure (stall) and branch flush, and injects a canonical NOP when the output is not valid. With the skid option compiled in, the fetch-side ready is a register output, so no combinational path runs from decode back into fetch.

## Interface

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- INST_WIDTH, 32, instruction width in bits.
- NOP_INST, 32'h00000013, instruction driven on id_inst_o when the output is invalid (RISC-V addi x0,x0,0).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  discard all held and incoming instructions this cycle.
- if_valid_i  input  1  fetch presents an instruction.
- if_pc_i  input  ADDR_WIDTH  fetch PC.
- if_inst_i  input  INST_WIDTH  fetched instruction.
- if_ready_o  output  1  block accepts the fetch word this cycle.
- id_valid_o  output  1  id_pc_o/id_inst_o hold a live instruction.
- id_pc_o  output  ADDR_WIDTH  PC to decode.
- id_inst_o  output  INST_WIDTH  instruction to decode; NOP_INST when id_valid_o=0.
- id_ready_i  input  1  decode consumes the output word this cycle.
- count_o  output  2  instructions held (0..2; 0..1 without skid).

## Operation

- Accept: if_valid_i && if_ready_o && !flush_i. Consume: id_valid_o && id_ready_i.
- Storage: output register (OUT) plus, with skid, one skid register (SKID). States: EMPTY (count 0), FULL (OUT valid), SKID (OUT and SKID valid).
- EMPTY: accept → FULL, OUT loads the input.
- FULL: consume without accept → EMPTY; consume with accept → FULL, OUT reloads; accept without consume → SKID, input goes to SKID; neither → hold.
- SKID: if_ready_o=0; consume → FULL, OUT ← SKID; otherwise hold.
- Order is strict FIFO; no word is duplicated or dropped except by flush.
- flush_i (any state): next cycle EMPTY, the input word of the flush cycle is dropped, and id_inst_o shows NOP_INST. Flush has priority over accept and consume; a word consumed in the flush cycle still counts as consumed by decode.
- id_pc_o holds its last value when invalid (don't-care for decode); id_inst_o is forced to NOP_INST.
- Reset (any state, including mid-stall): EMPTY, id_valid_o=0, id_pc_o=0, id_inst_o=NOP_INST, count_o=0, if_ready_o=1 from the first cycle after reset. Reset has priority over flush.

## Timing

- Latency: a word accepted at edge N is visible on id_* after edge N.
- Throughput: one word per cycle sustained while id_ready_i=1.
- With skid: if_ready_o = (state != SKID), registered; no path from id_ready_i or flush_i to if_ready_o.
- Without skid: if_ready_o = !id_valid_o || id_ready_i, combinational.
- id_valid_o, id_pc_o, id_inst_o and count_o are always register outputs.

## Configuration

- IF_ID_SKID_EN defined: the two-entry skid structure above; registered if_ready_o; count_o ranges 0..2.
- IF_ID_SKID_EN undefined: OUT register only; combinational if_ready_o; the SKID state does not exist; count_o ranges 0..1. Handshake, flush and reset semantics are otherwise identical.

## Test plan

- Reset: hold rst high 3 cycles with if_valid_i=1 → id_valid_o=0, id_inst_o=32'h00000013, id_pc_o=0, count_o=0, if_ready_o=1.
- Stream: PCs 0x0,0x4,0x8 with insts 0xA,0xB,0xC and id_ready_i=1 → each appears on id_* exactly one cycle later, back to back, id_valid_o=1 throughout.
- Stall with skid: feed 0x10/0x14 with id_ready_i=0 → OUT=0x10, SKID=0x14, count_o=2, if_ready_o=0; release → 0x10 then 0x14 on consecutive cycles, no loss or duplication.
- Flush in SKID state with a new word 0x18 presented → next cycle id_valid_o=0, id_inst_o=NOP, count_o=0, and 0x18 is never emitted.
- Simultaneous flush and reset → reset values; then flush alone while EMPTY → stays EMPTY.
- IF_ID_SKID_EN undefined: id_ready_i=0 while FULL → if_ready_o=0 in the same cycle; id_ready_i=1 → accept and consume in the same cycle.

Source files
------------

// File: rtl/if_id_buf.sv
// if_id_buf: IF/ID pipeline boundary between fetch and decode.
//
// Carries PC and instruction across a valid/ready handshake on both sides.
// Decode back-pressure stalls the buffer, flush_i drops everything held plus
// the word presented in the same cycle, and id_inst_o shows NOP_INST whenever
// id_valid_o is low.
//
// Build option: define IF_ID_SKID_EN to add a second (skid) entry. if_ready_o
// then comes straight from a register, so there is no combinational path from
// id_ready_i or flush_i back into fetch. Without it, only the output register
// exists and if_ready_o = !id_valid_o || id_ready_i.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   flush_i      discard held and incoming words this cycle
//   if_valid_i   fetch presents if_pc_i / if_inst_i
//   if_pc_i      fetch PC
//   if_inst_i    fetched instruction
//   if_ready_o   buffer accepts the fetch word this cycle
//   id_valid_o   id_pc_o / id_inst_o hold a live instruction
//   id_pc_o      PC to decode (holds last value when invalid)
//   id_inst_o    instruction to decode, NOP_INST when invalid
//   id_ready_i   decode consumes the output word this cycle
//   count_o      number of words held
module if_id_buf #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST = INST_WIDTH'(32'h00000013)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  if_valid_i,
    input  logic [ADDR_WIDTH-1:0] if_pc_i,
    input  logic [INST_WIDTH-1:0] if_inst_i,
    output logic                  if_ready_o,
    output logic                  id_valid_o,
    output logic [ADDR_WIDTH-1:0] id_pc_o,
    output logic [INST_WIDTH-1:0] id_inst_o,
    input  logic                  id_ready_i,
    output logic [1:0]            count_o
);

`ifdef IF_ID_SKID_EN
    typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;
`else
    typedef enum logic [0:0] {StEmpty, StFull} state_e;
`endif

    state_e                r_state;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic [1:0]            r_count;

    logic                  w_accept;
    logic                  w_consume;

`ifdef IF_ID_SKID_EN
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_skid_pc;
    logic [INST_WIDTH-1:0] r_skid_inst;

    assign if_ready_o = r_ready;
`else
    // Single entry: free a slot in the same cycle decode drains it.
    assign if_ready_o = !r_valid || id_ready_i;
`endif

    assign w_accept  = if_valid_i && if_ready_o && !flush_i;
    assign w_consume = r_valid && id_ready_i;

    assign id_valid_o = r_valid;
    assign id_pc_o    = r_pc;
    assign id_inst_o  = r_inst;
    assign count_o    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StEmpty;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_inst      <= NOP_INST;
            r_count     <= 2'd0;
`ifdef IF_ID_SKID_EN
            r_ready     <= 1'b1;
            r_skid_pc   <= '0;
            r_skid_inst <= NOP_INST;
`endif
        end else if (flush_i) begin
            // r_pc is left alone; only the instruction is forced to NOP.
            r_state <= StEmpty;
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_count <= 2'd0;
`ifdef IF_ID_SKID_EN
            r_ready <= 1'b1;
`endif
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_accept) begin
                        r_state <= StFull;
                        r_valid <= 1'b1;
                        r_pc    <= if_pc_i;
                        r_inst  <= if_inst_i;
                        r_count <= 2'd1;
                    end
                end
                StFull: begin
                    if (w_accept && w_consume) begin
                        r_pc   <= if_pc_i;
                        r_inst <= if_inst_i;
                    end else if (w_consume) begin
                        r_state <= StEmpty;
                        r_valid <= 1'b0;
                        r_inst  <= NOP_INST;
                        r_count <= 2'd0;
                    end
`ifdef IF_ID_SKID_EN
                    else if (w_accept) begin
                        // Decode stalled: park the new word behind OUT.
                        r_state     <= StSkid;
                        r_skid_pc   <= if_pc_i;
                        r_skid_inst <= if_inst_i;
                        r_ready     <= 1'b0;
                        r_count     <= 2'd2;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                StSkid: begin
                    if (w_consume) begin
                        r_state <= StFull;
                        r_pc    <= r_skid_pc;
                        r_inst  <= r_skid_inst;
                        r_ready <= 1'b1;
                        r_count <= 2'd1;
                    end
                end
`endif
                default: r_state <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf. A queue-based reference model (capacity
// 2 with IF_ID_SKID_EN, else 1) predicts every output each cycle.
module tb_if_id_buf;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_ID_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_ready_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
    logic [1:0]  count_o;

    if_id_buf dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_ready_i (id_ready_i),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } word_t;

    word_t       q[$];
    logic [31:0] last_pc;
    int          n_checks;
    int          n_errors;

    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [1:0]  e_count;
    logic        e_ready;
    logic        e_acc;

    // Apply inputs, predict this cycle's outputs, then move to the negedge.
    task automatic drive(input bit r, input bit fl, input bit v,
                         input logic [31:0] pc, input logic [31:0] inst, input bit rdy);
        rst        = r;
        flush_i    = fl;
        if_valid_i = v;
        if_pc_i    = pc;
        if_inst_i  = inst;
        id_ready_i = rdy;
        e_valid = (q.size() > 0);
        e_inst  = e_valid ? q[0].inst : NOP;
        e_pc    = e_valid ? q[0].pc : last_pc;
        e_count = 2'(q.size());
`ifdef IF_ID_SKID_EN
        e_ready = (q.size() < CAP);
`else
        e_ready = (q.size() == 0) || rdy;
`endif
        e_acc = v && e_ready && !fl && !r;
        @(negedge clk);
    endtask

    // Clock edge: update the model from the inputs driven this cycle.
    task automatic advance();
        word_t w;
        bit    cons;
        @(posedge clk);
        cons = (q.size() > 0) && id_ready_i;
        if (rst) begin
            q.delete();
            last_pc = '0;
        end else if (flush_i) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (e_acc) begin
                w.pc   = if_pc_i;
                w.inst = if_inst_i;
                q.push_back(w);
            end
        end
        if (q.size() > 0) last_pc = q[0].pc;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 32'h100 + 32'(i), $urandom, 1'($urandom));
            advance();
        end
        drive(0, 0, 0, '0, '0, 0);
        n_checks++;
        if ({id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {1'b0, 32'h0, NOP, 2'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL reset: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=0 pc=0 inst=%h cnt=0 rdy=1",
                     id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o, NOP);
        end
        advance();
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        int          idx;
        pcs = '{32'h0, 32'h4, 32'h8};
        ins = '{32'hA, 32'hB, 32'hC};
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 3) drive(0, 0, 1, pcs[idx], ins[idx], 1);
            else drive(0, 0, 0, '0, '0, 1);
            n_checks++;
            if ({id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {e_valid, e_pc, e_inst, e_count, e_ready}) begin
                n_errors++;
                $display("FAIL stream c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                         c, id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o,
                         e_valid, e_pc, e_inst, e_count, e_ready);
            end
            if (e_acc) idx++;
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] pcs [2];
        int          idx;
        pcs = '{32'h10, 32'h14};
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 2) drive(0, 0, 1, pcs[idx], 32'h1000 + pcs[idx], c >= 4);
            else drive(0, 0, 0, '0, '0, c >= 4);
            n_checks++;
            if ({id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {e_valid, e_pc, e_inst, e_count, e_ready}) begin
                n_errors++;
                $display("FAIL stall c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                         c, id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o,
                         e_valid, e_pc, e_inst, e_count, e_ready);
            end
            if (e_acc) idx++;
            advance();
        end
    endtask

    task automatic test_flush_skid();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: drive(0, 0, 1, 32'h10, 32'h2010, 0);
                1: drive(0, 0, 1, 32'h14, 32'h2014, 0);
                2: drive(0, 0, 1, 32'h18, 32'h2018, 0);
                3: drive(0, 1, 1, 32'h18, 32'h2018, 0);
                default: drive(0, 0, 0, '0, '0, 1);
            endcase
            n_checks++;
            if ({id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {e_valid, e_pc, e_inst, e_count, e_ready}) begin
                n_errors++;
                $display("FAIL flush c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                         c, id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o,
                         e_valid, e_pc, e_inst, e_count, e_ready);
            end
            if (c >= 4) begin
                n_checks++;
                if (id_valid_o !== 1'b0 || id_inst_o !== NOP) begin
                    n_errors++;
                    $display("FAIL flush_drop c%0d: got v=%b inst=%h, want v=0 inst=%h",
                             c, id_valid_o, id_inst_o, NOP);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drive(0, 0, 1, 32'h40, 32'h4040, 0);
                1: drive(1, 1, 1, 32'h44, 32'h4044, 0);
                2: drive(0, 1, 0, '0, '0, 1);
                default: drive(0, 0, 0, '0, '0, 1);
            endcase
            n_checks++;
            if (c >= 1 && {id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {e_valid, e_pc, e_inst, e_count, e_ready}) begin
                n_errors++;
                $display("FAIL flush_reset c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                         c, id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o,
                         e_valid, e_pc, e_inst, e_count, e_ready);
            end
            if (c >= 2) begin
                n_checks++;
                if (id_pc_o !== 32'h0 || count_o !== 2'd0) begin
                    n_errors++;
                    $display("FAIL flush_reset_vals c%0d: got pc=%h cnt=%0d, want pc=0 cnt=0",
                             c, id_pc_o, count_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        bit          rdy;
        pc = 32'h80;
        for (int c = 0; c < 8; c++) begin
            rdy = (c == 0) || (c >= 4);
            drive(0, 0, 1, pc, 32'h8000 + pc, rdy);
            n_checks++;
            if ({id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {e_valid, e_pc, e_inst, e_count, e_ready}) begin
                n_errors++;
                $display("FAIL back_to_back c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                         c, id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o,
                         e_valid, e_pc, e_inst, e_count, e_ready);
            end
            if (e_acc) pc = pc + 32'h4;
            advance();
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, '0, '0, 1);
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] inst;
        pc   = 32'h1000;
        inst = $urandom;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 97) == 0, ($urandom % 20) == 0, ($urandom % 4) != 0,
                  pc, inst, ($urandom % 3) != 0);
            n_checks++;
            if ({id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o} !== {e_valid, e_pc, e_inst, e_count, e_ready}) begin
                n_errors++;
                $display("FAIL random c%0d: got v=%b pc=%h inst=%h cnt=%0d rdy=%b, want v=%b pc=%h inst=%h cnt=%0d rdy=%b",
                         c, id_valid_o, id_pc_o, id_inst_o, count_o, if_ready_o,
                         e_valid, e_pc, e_inst, e_count, e_ready);
            end
            if (e_acc) begin
                pc   = pc + 32'h4;
                inst = $urandom;
            end
            advance();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        last_pc    = '0;
        rst        = 1'b1;
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        if_pc_i    = '0;
        if_inst_i  = '0;
        id_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush_skid();
        test_flush_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
